// File: rtl/memory_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (CPU and
// debug/loader) and main memory. The arbiter connects through the slave
// modport; the requesters and memory model sit on the master side.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  // Debug/loader port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  // Main memory
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output dbg_rdata, dbg_ack,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_rdata, dbg_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: CPU and debug/loader ports share one main memory.
// Each grant is IDLE -> ACC_x (one memory cycle) -> RESP (ack pulse) -> IDLE.
// Ties are round-robin unless the debug port holds dbg_lock, in which case it
// gets up to MAX_LOCK consecutive grants before the CPU is served.
module memory_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input logic              clk,
  input logic              rst,
  memory_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_DBG, RESP} state_t;
  typedef enum logic {GRANT_CPU, GRANT_DBG} grant_t;

  state_t            state, state_nxt;
  grant_t            last_grant, grant_nxt;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_acc;
  logic              start;

  // Arbitration: decide next state, next grant owner and lock counter
  always_comb begin
    state_nxt    = state;
    grant_nxt    = last_grant;
    lock_cnt_nxt = lock_cnt;
    start        = 1'b0;
    if (!bus.dbg_lock) lock_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (bus.cpu_req && bus.dbg_req) begin
          if (bus.dbg_lock && (lock_cnt < LOCK_MAX)) grant_nxt = GRANT_DBG;
          else if (bus.dbg_lock)                     grant_nxt = GRANT_CPU;
          else if (last_grant == GRANT_DBG)          grant_nxt = GRANT_CPU;
          else                                       grant_nxt = GRANT_DBG;
        end else if (bus.cpu_req) begin
          grant_nxt = GRANT_CPU;
        end else if (bus.dbg_req) begin
          grant_nxt = GRANT_DBG;
        end
        if (bus.cpu_req || bus.dbg_req) begin
          start = 1'b1;
          if (grant_nxt == GRANT_CPU) begin
            state_nxt    = ACC_CPU;
            lock_cnt_nxt = '0;
          end else begin
            state_nxt = ACC_DBG;
            if (bus.dbg_lock && (lock_cnt < LOCK_MAX))
              lock_cnt_nxt = lock_cnt + CNT_W'(1);
          end
        end
      end
      ACC_CPU, ACC_DBG: state_nxt = RESP;
      RESP:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // State, grant owner and lock counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_DBG;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  // Capture the granted request at the sampling edge so the access still
  // completes with the sampled values if the requester drops it afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
    end else if (start) begin
      acc_we    <= (grant_nxt == GRANT_CPU) ? bus.cpu_we    : bus.dbg_we;
      acc_addr  <= (grant_nxt == GRANT_CPU) ? bus.cpu_addr  : bus.dbg_addr;
      acc_wdata <= (grant_nxt == GRANT_CPU) ? bus.cpu_wdata : bus.dbg_wdata;
    end
  end

  // Read data capture at the end of the access cycle, per granted port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
    end else begin
      if (state == ACC_CPU && !acc_we) bus.cpu_rdata <= bus.mem_rdata;
      if (state == ACC_DBG && !acc_we) bus.dbg_rdata <= bus.mem_rdata;
    end
  end

  // Memory strobes, bus and handshake outputs decoded from state
  always_comb begin
    in_acc        = (state == ACC_CPU) || (state == ACC_DBG);
    bus.mem_read  = in_acc && !acc_we;
    bus.mem_write = in_acc && acc_we;
    bus.mem_addr  = in_acc ? acc_addr  : '0;
    bus.mem_wdata = in_acc ? acc_wdata : '0;
    bus.cpu_ack   = (state == RESP) && (last_grant == GRANT_CPU);
    bus.dbg_ack   = (state == RESP) && (last_grant == GRANT_DBG);
    bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter DATA_W, default 32, width of all data ports.
REQ-003 Parameter MAX_LOCK, default 16, maximum consecutive debug grants while dbg_lock is high.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cpu_req  in  1  CPU (multicycle controller) access request, held until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-008 cpu_addr  in  ADDR_W  CPU word address (IorD mux output).
REQ-009 cpu_wdata  in  DATA_W  CPU write data (DataWrite mux output).
REQ-010 cpu_rdata  out  DATA_W  registered read data for CPU.
REQ-011 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-012 cpu_stall  out  1  freeze signal to controller = cpu_req AND NOT cpu_ack.
REQ-013 dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug/loader port; same rules as CPU port.
REQ-014 dbg_lock  in  1  request back-to-back debug grants.
REQ-015 dbg_rdata  out  DATA_W; dbg_ack  out  1  debug read data and completion pulse.
REQ-016 mem_read, mem_write  out  1 each  strobes to main memory memRead/memWrite.
REQ-017 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  memory address and write data.
REQ-018 mem_rdata  in  DATA_W  combinational memory data_out.

Function
REQ-019 FSM states: IDLE, ACC_CPU, ACC_DBG, RESP; state register is the only arbitration decision point.
REQ-020 IDLE: requests sampled at clock edge; neither high -> stay IDLE.
REQ-021 One request high -> ACC state of that port.
REQ-022 Both high, lock inactive -> round-robin: port not in last_grant wins; last_grant updated on entry to ACC.
REQ-023 Both high with dbg_lock=1 and lock_cnt < MAX_LOCK -> ACC_DBG regardless of last_grant.
REQ-024 lock_cnt increments on each ACC_DBG entry while dbg_lock=1; clears when dbg_lock=0 or on any ACC_CPU entry; saturates at MAX_LOCK.
REQ-025 lock_cnt = MAX_LOCK with CPU requesting -> next grant to CPU (starvation bound).
REQ-026 ACC_x: exactly one cycle; mem_addr/mem_wdata = granted port signals; mem_read = NOT we, mem_write = we; next state RESP.
REQ-027 At ACC_x exit edge, mem_rdata captured into granted port rdata register (reads only); other port rdata unchanged.
REQ-028 RESP: granted port ack = 1 for exactly this cycle; next state IDLE.
REQ-029 Latency: request sampled at edge k -> memory access in cycle k+1 -> ack high in cycle k+2; minimum 3 cycles between grants.
REQ-030 mem_read and mem_write low in IDLE and RESP; never both high.
REQ-031 Request dropped after grant: access still completes and ack still pulses; dropped before sampling: ignored.
REQ-032 cpu_ack and dbg_ack never high in the same cycle.
REQ-033 mem_addr and mem_wdata = 0 when no ACC state.

Reset
REQ-034 rst=1 forces immediately: state=IDLE, last_grant=DBG (CPU wins first tie), lock_cnt=0.
REQ-035 rst=1 forces immediately: all ack, mem_read, mem_write = 0; cpu_rdata=0; dbg_rdata=0.
REQ-036 Reset during ACC or RESP aborts the access with no ack; memory strobes drop in the same cycle.

Verification
REQ-037 CPU read alone, addr 0x10, mem holds 0xDEADBEEF -> mem_read high 1 cycle; cpu_ack 2 cycles after sample; cpu_rdata=0xDEADBEEF; cpu_stall high until ack.
REQ-038 Debug write addr 0x20 data 0x12345678, then CPU read 0x20 -> cpu_rdata=0x12345678; dbg_ack precedes cpu_ack.
REQ-039 Both requesting continuously, dbg_lock=0 -> grants alternate CPU, DBG, CPU, DBG from reset.
REQ-040 dbg_lock=1, both requesting, MAX_LOCK=4 -> 4 debug grants, then 1 CPU grant, then lock_cnt=0.
REQ-041 rst asserted in ACC_CPU write -> mem_write low same cycle; no cpu_ack; state IDLE after release.
REQ-042 Every cycle of random traffic -> mem_read AND mem_write never both high; acks mutually exclusive.
